// File: rtl/alu_issue_decode.sv
// RV32I decode/issue stage: decodes into the ALU control bundle and holds results in a two-entry skid buffer.
// Optional macro DEC_ILLEGAL_TRAP_EN adds the out_illegal port.
module alu_issue_decode #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned ALU_CTRL_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic [4:0]               rs1_addr,
  output logic [4:0]               rs2_addr,
  input  logic [XLEN-1:0]          rs1_data,
  input  logic [XLEN-1:0]          rs2_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_rdata1,
  output logic [XLEN-1:0]          out_rdata2,
  output logic [XLEN-1:0]          out_imm,
  output logic [ALU_CTRL_BITS-1:0] out_alu_ctrl,
  output logic                     out_alu_pcsrc,
  output logic                     out_alu_immsrc,
  output logic [4:0]               out_rd,
  output logic [2:0]               out_funct3,
  output logic                     out_reg_we,
  output logic                     out_mem_re,
  output logic                     out_mem_we
`ifdef DEC_ILLEGAL_TRAP_EN
  ,
  output logic                     out_illegal
`endif
);

  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_ADD   = ALU_CTRL_BITS'(0);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SUB   = ALU_CTRL_BITS'(1);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SLL   = ALU_CTRL_BITS'(2);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SLT   = ALU_CTRL_BITS'(3);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SLTU  = ALU_CTRL_BITS'(4);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_XOR   = ALU_CTRL_BITS'(5);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SRL   = ALU_CTRL_BITS'(6);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_SRA   = ALU_CTRL_BITS'(7);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_OR    = ALU_CTRL_BITS'(8);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_AND   = ALU_CTRL_BITS'(9);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_BEQ   = ALU_CTRL_BITS'(10);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_BNE   = ALU_CTRL_BITS'(11);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_BLT   = ALU_CTRL_BITS'(12);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_BGE   = ALU_CTRL_BITS'(13);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_BLTU  = ALU_CTRL_BITS'(14);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_BGEU  = ALU_CTRL_BITS'(15);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_JAL   = ALU_CTRL_BITS'(16);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_JALR  = ALU_CTRL_BITS'(17);
  localparam logic [ALU_CTRL_BITS-1:0] ALUCTRL_AUIPC = ALU_CTRL_BITS'(18);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [XLEN-1:0]          rdata1;
    logic [XLEN-1:0]          rdata2;
    logic [XLEN-1:0]          imm;
    logic [ALU_CTRL_BITS-1:0] alu_ctrl;
    logic                     pcsrc;
    logic                     immsrc;
    logic [4:0]               rd;
    logic [2:0]               funct3;
    logic                     reg_we;
    logic                     mem_re;
    logic                     mem_we;
`ifdef DEC_ILLEGAL_TRAP_EN
    logic                     illegal;
`endif
  } payload_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            illegal;
  payload_t        dec;
  payload_t        main_q, skid_q;
  state_t          state, state_nxt;
  logic            load_main, load_skid, skid_to_main;
  logic            in_xfer, out_xfer;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign funct7_5 = in_inst[30];

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  assign rs1_addr = (opcode == OPC_LUI || opcode == OPC_JAL) ? 5'd0 : in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  // Instruction decode into the payload bundle
  always_comb begin
    dec        = '0;
    illegal    = 1'b0;
    dec.pc     = in_pc;
    dec.rdata1 = rs1_data;
    dec.rdata2 = rs2_data;
    dec.rd     = in_inst[11:7];
    dec.funct3 = funct3;
    unique case (opcode)
      OPC_LUI:   begin dec.alu_ctrl = ALUCTRL_ADD;   dec.immsrc = 1'b1; dec.imm = imm_u; dec.reg_we = 1'b1; end
      OPC_AUIPC: begin dec.alu_ctrl = ALUCTRL_AUIPC; dec.pcsrc = 1'b1; dec.immsrc = 1'b1; dec.imm = imm_u; dec.reg_we = 1'b1; end
      OPC_JAL:   begin dec.alu_ctrl = ALUCTRL_JAL;   dec.pcsrc = 1'b1; dec.immsrc = 1'b1; dec.imm = imm_j; dec.reg_we = 1'b1; end
      OPC_JALR:  begin dec.alu_ctrl = ALUCTRL_JALR;  dec.immsrc = 1'b1; dec.imm = imm_i; dec.reg_we = 1'b1; end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        unique case (funct3)
          3'b000:  dec.alu_ctrl = ALUCTRL_BEQ;
          3'b001:  dec.alu_ctrl = ALUCTRL_BNE;
          3'b100:  dec.alu_ctrl = ALUCTRL_BLT;
          3'b101:  dec.alu_ctrl = ALUCTRL_BGE;
          3'b110:  dec.alu_ctrl = ALUCTRL_BLTU;
          3'b111:  dec.alu_ctrl = ALUCTRL_BGEU;
          default: illegal      = 1'b1;
        endcase
      end
      OPC_LOAD:  begin dec.alu_ctrl = ALUCTRL_ADD; dec.immsrc = 1'b1; dec.imm = imm_i; dec.mem_re = 1'b1; dec.reg_we = 1'b1; end
      OPC_STORE: begin dec.alu_ctrl = ALUCTRL_ADD; dec.immsrc = 1'b1; dec.imm = imm_s; dec.mem_we = 1'b1; end
      OPC_OPIMM, OPC_OP: begin
        dec.immsrc = (opcode == OPC_OPIMM);
        dec.imm    = (opcode == OPC_OPIMM) ? imm_i : '0;
        dec.reg_we = 1'b1;
        unique case (funct3)
          3'b000:  dec.alu_ctrl = (opcode == OPC_OP && funct7_5) ? ALUCTRL_SUB : ALUCTRL_ADD;
          3'b001:  dec.alu_ctrl = ALUCTRL_SLL;
          3'b010:  dec.alu_ctrl = ALUCTRL_SLT;
          3'b011:  dec.alu_ctrl = ALUCTRL_SLTU;
          3'b100:  dec.alu_ctrl = ALUCTRL_XOR;
          3'b101:  dec.alu_ctrl = funct7_5 ? ALUCTRL_SRA : ALUCTRL_SRL;
          3'b110:  dec.alu_ctrl = ALUCTRL_OR;
          default: dec.alu_ctrl = ALUCTRL_AND;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings issue as an ADD with no side effects
    if (illegal) begin
      dec.alu_ctrl = ALUCTRL_ADD;
      dec.pcsrc    = 1'b0;
      dec.immsrc   = 1'b0;
      dec.imm      = '0;
      dec.reg_we   = 1'b0;
      dec.mem_re   = 1'b0;
      dec.mem_we   = 1'b0;
    end
`ifdef DEC_ILLEGAL_TRAP_EN
    dec.illegal = illegal;
`endif
    if (dec.rd == 5'd0) dec.reg_we = 1'b0;
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Skid buffer next-state and load selects
  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (in_xfer) begin load_main = 1'b1; state_nxt = ST_ONE; end
        ST_ONE: begin
          if (in_xfer && out_xfer) load_main = 1'b1;
          else if (in_xfer) begin load_skid = 1'b1; state_nxt = ST_TWO; end
          else if (out_xfer) state_nxt = ST_EMPTY;
        end
        ST_TWO: if (out_xfer) begin skid_to_main = 1'b1; state_nxt = ST_ONE; end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != ST_TWO);
      out_valid <= (state_nxt != ST_EMPTY);
      if (load_main)         main_q <= dec;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= dec;
    end
  end

  assign out_pc         = main_q.pc;
  assign out_rdata1     = main_q.rdata1;
  assign out_rdata2     = main_q.rdata2;
  assign out_imm        = main_q.imm;
  assign out_alu_ctrl   = main_q.alu_ctrl;
  assign out_alu_pcsrc  = main_q.pcsrc;
  assign out_alu_immsrc = main_q.immsrc;
  assign out_rd         = main_q.rd;
  assign out_funct3     = main_q.funct3;
  assign out_reg_we     = main_q.reg_we;
  assign out_mem_re     = main_q.mem_re;
  assign out_mem_we     = main_q.mem_we;
`ifdef DEC_ILLEGAL_TRAP_EN
  assign out_illegal    = main_q.illegal;
`endif

endmodule
